// File: rtl/spectrum_peak_finder_if.sv
// Stream interface for spectrum_peak_finder: per-bin magnitude input and
// per-frame peak result output. The peak finder sits on the slave side.
interface spectrum_peak_finder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_LOG2     = 8
);
  logic [DATA_WIDTH-1:0] mag_in;
  logic                  mag_valid;
  logic                  mag_last;
  logic                  peak_valid;
  logic [DATA_WIDTH-1:0] peak_mag;
  logic [N_LOG2-1:0]     peak_idx;
  logic                  frame_err;

  modport master (
    output mag_in, mag_valid, mag_last,
    input  peak_valid, peak_mag, peak_idx, frame_err
  );

  modport slave (
    input  mag_in, mag_valid, mag_last,
    output peak_valid, peak_mag, peak_idx, frame_err
  );
endinterface

// File: rtl/spectrum_peak_finder.sv
// spectrum_peak_finder: per-frame max search over FFT bin magnitudes.
// Stage 0 registers the (combinational) magnitude input; stage 1 scans for the
// largest value, earliest index on ties, and strobes the result at frame close.
// Optional build macro: SPECTRUM_PEAK_DC_SKIP_EN excludes bin 0 from the search.
module spectrum_peak_finder #(
  parameter int DATA_WIDTH = 16,
  parameter int N_LOG2     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  spectrum_peak_finder_if.slave bus
);
  localparam logic [N_LOG2-1:0] LAST_BIN = '1;
`ifdef SPECTRUM_PEAK_DC_SKIP_EN
  localparam logic [N_LOG2-1:0] BIN_ONE  = 1;
`endif

  logic [DATA_WIDTH-1:0] s0_mag;
  logic                  s0_valid, s0_last;
  logic [N_LOG2-1:0]     bin_cnt, max_idx, nxt_idx;
  logic [DATA_WIDTH-1:0] max_mag, nxt_mag;
  logic                  at_end, close;

  // Input register: pipeline break after the magnitude stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_mag   <= '0;
      s0_valid <= 1'b0;
      s0_last  <= 1'b0;
    end else begin
      s0_mag   <= bus.mag_in;
      s0_valid <= bus.mag_valid;
      s0_last  <= bus.mag_last;
    end
  end

  // Running max including the current bin; strict compare keeps the earliest index.
  always_comb begin
    nxt_mag = max_mag;
    nxt_idx = max_idx;
`ifdef SPECTRUM_PEAK_DC_SKIP_EN
    // Bin 0 only clears the search; bin 1 seeds it unconditionally so the
    // reported index is never 0 once the frame reaches bin 1.
    if (bin_cnt == '0) begin
      nxt_mag = '0;
      nxt_idx = '0;
    end else if (bin_cnt == BIN_ONE || s0_mag > max_mag) begin
      nxt_mag = s0_mag;
      nxt_idx = bin_cnt;
    end
`else
    if (bin_cnt == '0 || s0_mag > max_mag) begin
      nxt_mag = s0_mag;
      nxt_idx = bin_cnt;
    end
`endif
  end

  assign at_end = (bin_cnt == LAST_BIN);
  assign close  = s0_valid && (s0_last || at_end);

  // Scan state and result registers; a close also restarts the bin counter so
  // the next frame can begin in the strobe cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_cnt        <= '0;
      max_mag        <= '0;
      max_idx        <= '0;
      bus.peak_valid <= 1'b0;
      bus.peak_mag   <= '0;
      bus.peak_idx   <= '0;
      bus.frame_err  <= 1'b0;
    end else begin
      bus.peak_valid <= close;
      if (s0_valid) begin
        max_mag <= nxt_mag;
        max_idx <= nxt_idx;
        bin_cnt <= close ? '0 : bin_cnt + 1'b1;
      end
      if (close) begin
        bus.peak_mag  <= nxt_mag;
        bus.peak_idx  <= nxt_idx;
        // Short frame (last before final bin) or long frame (final bin, no last).
        bus.frame_err <= s0_last ^ at_end;
      end
    end
  end
endmodule

// File: tb/tb_spectrum_peak_finder.sv
// Directed bench for spectrum_peak_finder with N_LOG2=3 (8-bin frames).
module tb_spectrum_peak_finder;
  localparam int DW = 16;
  localparam int NL = 3;
`ifdef SPECTRUM_PEAK_DC_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct packed {
    logic [15:0] m;
    logic [2:0]  i;
    logic        e;
    logic [31:0] c;
  } res_t;

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][15:0] m;
    logic             last;
    logic [15:0]      em;
    logic [2:0]       ei;
    logic             ee;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spectrum_peak_finder_if #(.DATA_WIDTH(DW), .N_LOG2(NL)) bus ();
  spectrum_peak_finder #(.DATA_WIDTH(DW), .N_LOG2(NL)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  res_t got[$];
  res_t expq[$];
  vec_t tbl[8];

  function automatic logic [7:0][15:0] b8(int a0, int a1, int a2, int a3,
                                          int a4, int a5, int a6, int a7);
    logic [7:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // One clock: sample the result strobe, then drive the next input.
  task automatic step(bit v, bit l, logic [15:0] m);
    @(negedge clk);
    cyc++;
    if (bus.peak_valid === 1'b1)
      got.push_back(res_t'{bus.peak_mag, bus.peak_idx, bus.frame_err, 32'(cyc)});
    bus.mag_valid = v;
    bus.mag_last  = l;
    bus.mag_in    = m;
  endtask

  task automatic expect_res(logic [15:0] m, logic [2:0] i, logic e);
    expq.push_back(res_t'{m, i, e, 32'(cyc + 2)});
  endtask

  task automatic compare_all(string tag);
    chk($sformatf("%s strobe_count", tag), 32'(got.size()), 32'(expq.size()));
    for (int k = 0; k < expq.size() && k < got.size(); k++) begin
      chk($sformatf("%s[%0d] strobe_cycle", tag, k), got[k].c, expq[k].c);
      chk($sformatf("%s[%0d] peak_mag", tag, k), 32'(got[k].m), 32'(expq[k].m));
      chk($sformatf("%s[%0d] peak_idx", tag, k), 32'(got[k].i), 32'(expq[k].i));
      chk($sformatf("%s[%0d] frame_err", tag, k), 32'(got[k].e), 32'(expq[k].e));
    end
    got.delete();
    expq.delete();
  endtask

  initial begin
    logic [7:0][15:0] ga, gb;
    rst = 1'b1;
    bus.mag_valid = 1'b0;
    bus.mag_last  = 1'b0;
    bus.mag_in    = '0;
    repeat (2) @(negedge clk);
    chk("reset peak_valid", 32'(bus.peak_valid), 0);
    chk("reset peak_mag", 32'(bus.peak_mag), 0);
    chk("reset peak_idx", 32'(bus.peak_idx), 0);
    chk("reset frame_err", 32'(bus.frame_err), 0);
    rst = 1'b0;

    // {bins, magnitudes (bin 0 first), last on final bin, peak_mag, peak_idx, frame_err}
    tbl[0] = '{4'd8, b8(5, 9, 2, 9, 1, 0, 3, 4), 1'b1, 16'd9, 3'd1, 1'b0};
    tbl[1] = '{4'd8, b8(100, 9, 2, 9, 1, 0, 3, 4), 1'b1,
               SKIP ? 16'd9 : 16'd100, SKIP ? 3'd1 : 3'd0, 1'b0};
    tbl[2] = '{4'd3, b8(7, 8, 6, 0, 0, 0, 0, 0), 1'b1, 16'd8, 3'd1, 1'b1};
    tbl[3] = '{4'd8, b8(0, 1, 2, 3, 4, 5, 6, 7), 1'b0, 16'd7, 3'd7, 1'b1};
    tbl[4] = '{4'd1, b8(3, 0, 0, 0, 0, 0, 0, 0), 1'b1, SKIP ? 16'd0 : 16'd3, 3'd0, 1'b1};
    tbl[5] = '{4'd8, b8(4, 4, 4, 4, 4, 4, 4, 4), 1'b1, 16'd4, SKIP ? 3'd1 : 3'd0, 1'b0};
    tbl[6] = '{4'd8, b8(1, 2, 3, 4, 5, 6, 7, 8), 1'b1, 16'd8, 3'd7, 1'b0};
    tbl[7] = '{4'd8, b8(0, 0, 0, 0, 0, 0, 0, 0), 1'b1, 16'd0, SKIP ? 3'd1 : 3'd0, 1'b0};

    // Back-to-back contiguous frames from the table.
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < int'(tbl[i].n); k++)
        step(1'b1, tbl[i].last && (k == int'(tbl[i].n) - 1), tbl[i].m[k]);
      expect_res(tbl[i].em, tbl[i].ei, tbl[i].ee);
    end
    repeat (3) step(1'b0, 1'b0, '0);
    compare_all("table");

    // Gapped frame (idle cycle between bins) then a contiguous frame with no bubble.
    ga = b8(3, 1, 4, 1, 5, 9, 2, 6);
    gb = b8(2, 7, 1, 8, 2, 8, 1, 8);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, k == 7, ga[k]);
      if (k != 7) step(1'b0, 1'b1, 16'hdead);
    end
    expect_res(16'd9, 3'd5, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, k == 7, gb[k]);
    expect_res(16'd8, SKIP ? 3'd3 : 3'd3, 1'b0);
    repeat (3) step(1'b0, 1'b0, '0);
    compare_all("gap_b2b");
    chk("held peak_mag", 32'(bus.peak_mag), 8);
    chk("held peak_idx", 32'(bus.peak_idx), 3);

    // Reset in the middle of a frame: partial frame discarded, outputs cleared.
    step(1'b1, 1'b0, 16'd50);
    step(1'b1, 1'b0, 16'd60);
    step(1'b1, 1'b0, 16'd70);
    step(1'b0, 1'b0, '0);
    rst = 1'b1;
    #1;
    chk("midrst peak_valid", 32'(bus.peak_valid), 0);
    chk("midrst peak_mag", 32'(bus.peak_mag), 0);
    chk("midrst peak_idx", 32'(bus.peak_idx), 0);
    chk("midrst frame_err", 32'(bus.frame_err), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) step(1'b0, 1'b0, '0);
    compare_all("after_rst");

    // Fresh frame after reset starts at bin 0.
    step(1'b1, 1'b0, 16'd1);
    step(1'b1, 1'b0, 16'd1);
    step(1'b1, 1'b1, 16'd9);
    expect_res(16'd9, 3'd2, 1'b1);
    repeat (3) step(1'b0, 1'b0, '0);
    compare_all("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spectrum_peak_finder.md
# spectrum_peak_finder

Downstream consumer of the magnitude stage. Takes one unsigned magnitude per FFT bin, in natural bin order, and tracks the largest value and its bin index across each frame. At frame end it emits a one-cycle result strobe carrying the peak magnitude, the peak bin index and a framing-error flag. It registers the combinational magnitude output on entry, so the block also serves as the pipeline break after the square-root logic.

## Interface
- DATA_WIDTH, 16, magnitude width; matches the magnitude stage output width.
- N_LOG2, 8, log2 of the frame length; a frame is 2^N_LOG2 bins.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- mag_in  in  DATA_WIDTH  unsigned magnitude of the current bin.
- mag_valid  in  1  mag_in is valid this cycle; no backpressure, so every valid cycle is accepted.
- mag_last  in  1  qualifies mag_valid; marks the final bin of a frame.
- peak_valid  out  1  one-cycle strobe; a frame result is available.
- peak_mag  out  DATA_WIDTH  largest magnitude in the frame; held until the next result.
- peak_idx  out  N_LOG2  bin index of peak_mag; held until the next result.
- frame_err  out  1  latched with each result; high if the frame length was not exactly 2^N_LOG2.

## Operation
- Stage 0 (input register): capture mag_in, mag_valid and mag_last every cycle into s0_mag, s0_valid and s0_last.
- Stage 1 (scan): acts on s0_valid only.
- bin_cnt (N_LOG2 bits) holds the index of the bin being processed. It resets to 0 and returns to 0 after every frame close.
- First bin of a frame (bin_cnt==0): load the running max from s0_mag and set max_idx to 0, regardless of the previous contents.
- Later bins: update the running max and index only if s0_mag > max (strict comparison).
  - On ties the earliest index wins.
- Frame close happens on whichever comes first:
  - s0_last=1, or
  - bin_cnt==2^N_LOG2-1.
- Result of a close:
  - peak_mag and peak_idx are loaded with the final max, including the closing bin's own compare.
  - peak_valid=1 for one cycle.
  - bin_cnt returns to 0.
- frame_err is set at close in two cases:
  - s0_last arrived with bin_cnt!=2^N_LOG2-1 (short frame).
  - bin_cnt==2^N_LOG2-1 without s0_last (long frame). The next valid sample starts a new frame.
- Gaps are allowed: mag_valid may drop for any number of cycles mid-frame, and state holds.
- Reset mid-frame: the partial frame is discarded and no result is produced.
- Reset values: peak_valid=0, peak_mag=0, peak_idx=0, frame_err=0, bin_cnt=0, running max=0, all stage-0 registers=0.

## Timing
- Let E be the edge that samples the final bin on mag_in. Stage 0 holds that bin after E.
- At E+1 the outputs update:
  - peak_valid is high between E+1 and E+2.
  - peak_mag, peak_idx and frame_err are valid from E+1 and held until the next close.
- Input-to-strobe latency is 2 edges.
- Back-to-back frames: the first bin of the next frame may be sampled at E+1. The scan restarts in the same cycle the result strobe is high, with no bubble.
- Throughput: one bin per clock sustained.
- The critical path is a single DATA_WIDTH comparator plus the max/idx mux.

## Configuration
- SPECTRUM_PEAK_DC_SKIP_EN defined:
  - Bin 0 is counted but excluded from the search. The search starts from the first bin with index 1.
  - peak_idx is never 0 unless the frame closes at bin 0. A 1-bin frame reports peak_mag=0, peak_idx=0 and frame_err=1.
- Not defined: bin 0 participates like every other bin.
- Framing, latency and error behaviour are identical in both builds.

## Test plan
- N_LOG2=3, contiguous frame 5,9,2,9,1,0,3,4 with mag_last on bin 7 -> peak_valid at E+1, peak_mag=9, peak_idx=1, frame_err=0.
- Same frame, build with DC_SKIP_EN, bin 0=100 -> peak_mag=9, peak_idx=1.
- Build without DC_SKIP_EN, same stimulus -> peak_mag=100, peak_idx=0.
- Short frame: 3 bins 7,8,6 with mag_last on the 3rd -> peak_mag=8, peak_idx=1, frame_err=1; the next frame starts at idx 0.
- Long frame: 8 bins 0..7 with no mag_last -> result after bin 7 with peak_mag=7, peak_idx=7, frame_err=1. A following mag_last-tagged bin of value 3 closes as a 1-bin short frame with peak_mag=3, frame_err=1.
- Gapped input (mag_valid toggling every other cycle) followed immediately by a second back-to-back frame -> two strobes with correct independent results. Assert rst mid-frame -> all outputs 0 and no strobe for the aborted frame.
